// File: rtl/ibexc_dbus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ibexc_dbus_pkg
// Purpose  : Shared data-bus payload/response types and source IDs for the
//            two-master data-bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ibexc_dbus_pkg;

    // 32 data bits plus the capability valid-tag bit
    localparam int unsigned DataWidth = 33;

    typedef struct packed {
        logic                 we;
        logic [3:0]           be;
        logic [31:0]          addr;
        logic [DataWidth-1:0] wdata;
        logic                 is_cap;
    } dbus_req_t;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic                 err;
    } dbus_rsp_t;

    typedef enum logic {
        SrcCore = 1'b0,
        SrcRvk  = 1'b1
    } dbus_src_e;

endpackage
`default_nettype wire

// File: rtl/ibexc_dbus_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ibexc_dbus_id_fifo
// Purpose  : Synchronous FIFO of transaction source IDs, one entry per
//            granted-but-unanswered bus transfer.
// Revision : 1.0 - initial release
// ============================================================================
module ibexc_dbus_id_fifo
    import ibexc_dbus_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  dbus_src_e push_src_i,
    input  logic      pop_i,
    output logic      full_o,
    output logic      empty_o,
    output dbus_src_e head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    dbus_src_e       mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_d, wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_d, rd_ptr_q;
    logic [CntW-1:0] count_d, count_q;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_src_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ibexc_dbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ibexc_dbus_arbiter
// Purpose  : Shares one data-memory port between the core LSU (M0) and the
//            revocation engine (M1); fixed priority with starvation override.
// Revision : 1.0 - initial release
// ============================================================================
module ibexc_dbus_arbiter
    import ibexc_dbus_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned StarveLimit    = 8
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      m0_req_i,
    input  dbus_req_t m0_pld_i,
    output logic      m0_gnt_o,
    output logic      m0_rvalid_o,
    output dbus_rsp_t m0_rsp_o,
    input  logic      m1_req_i,
    input  dbus_req_t m1_pld_i,
    output logic      m1_gnt_o,
    output logic      m1_rvalid_o,
    output dbus_rsp_t m1_rsp_o,
    output logic      s_req_o,
    output dbus_req_t s_pld_o,
    input  logic      s_gnt_i,
    input  logic      s_rvalid_i,
    input  dbus_rsp_t s_rsp_i,
    output logic      busy_o
);

    localparam int unsigned StarveW = $clog2(StarveLimit + 1);

    dbus_src_e          sel_d, sel_q;
    logic               lock_d, lock_q;
    logic [StarveW-1:0] starve_d, starve_q;
    logic               starved;
    logic               req;
    logic               gnt;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    dbus_src_e          fifo_head;

    always_comb begin
        starved = (starve_q == StarveW'(StarveLimit));
        sel_d   = sel_q;
        if (!lock_q) begin
            if (m1_req_i && (starved || !m0_req_i)) begin
                sel_d = SrcRvk;
            end else if (m0_req_i) begin
                sel_d = SrcCore;
            end
        end
    end

    // Full is judged on registered occupancy, so a same-cycle response never
    // opens a combinational path from s_rvalid_i to s_req_o.
    assign req     = !rst_i && !fifo_full && ((sel_d == SrcRvk) ? m1_req_i : m0_req_i);
    assign gnt     = req && s_gnt_i;
    assign pop     = !rst_i && s_rvalid_i && !fifo_empty;

    assign s_req_o = req;
    assign s_pld_o = rst_i ? '0 : ((sel_d == SrcRvk) ? m1_pld_i : m0_pld_i);

    assign m0_gnt_o    = gnt && (sel_d == SrcCore);
    assign m1_gnt_o    = gnt && (sel_d == SrcRvk);
    assign m0_rvalid_o = pop && (fifo_head == SrcCore);
    assign m1_rvalid_o = pop && (fifo_head == SrcRvk);
    assign m0_rsp_o    = rst_i ? '0 : s_rsp_i;
    assign m1_rsp_o    = rst_i ? '0 : s_rsp_i;
    assign busy_o      = !rst_i && !fifo_empty;

    // Lock drops by itself if the locked master withdraws, since req falls.
    assign lock_d = req && !s_gnt_i;

    always_comb begin
        starve_d = '0;
        if (m1_req_i && !m1_gnt_o) begin
            starve_d = starved ? starve_q : starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q    <= SrcCore;
            lock_q   <= 1'b0;
            starve_q <= '0;
        end else begin
            sel_q    <= sel_d;
            lock_q   <= lock_d;
            starve_q <= starve_d;
        end
    end

    ibexc_dbus_id_fifo #(
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (gnt),
        .push_src_i (sel_d),
        .pop_i      (pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (fifo_head)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(s_rvalid_i && fifo_empty))
                else $warning("ibexc_dbus_arbiter: unsolicited rvalid dropped");
            assert (!(lock_q && !((sel_q == SrcRvk) ? m1_req_i : m0_req_i)))
                else $error("ibexc_dbus_arbiter: locked master withdrew its request");
        end
    end
`endif

endmodule
`default_nettype wire
